// File: rtl/seg_scan_scheduler_if.sv
// Load-side handshake for seg_scan_scheduler: request lines plus valid/ready.
interface seg_scan_scheduler_if;
    logic [15:0] in;
    logic        load_valid;
    logic        load_ready;

    modport master (
        output in,
        output load_valid,
        input  load_ready
    );

    modport slave (
        input  in,
        input  load_valid,
        output load_ready
    );
endinterface

// File: rtl/seg_scan_scheduler.sv
// Four-digit multiplexed seven-segment scan scheduler with priority-encoded loading.
// Define SEG_SCAN_MULTIHOT_ERR_EN to enable the sticky multi-hot error flag.
module seg_scan_scheduler #(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned GAP_CYC  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg_scan_scheduler_if.slave   load,
    input  logic                  clear,
    output logic [3:0]            code,
    output logic                  blank,
    output logic [3:0]            digit_sel,
    output logic                  err
);

    localparam int unsigned SCAN_W = $clog2(SCAN_DIV);

    typedef enum logic {
        SCAN,
        GAP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [SCAN_W-1:0] scan_cnt;
    logic [7:0]        gap_cnt;
    logic [1:0]        idx;
    logic [3:0][3:0]   d_val;
    logic [3:0]        d_vld;
    logic [3:0]        code_last;
    logic [3:0]        enc;
    logic              accept;
    logic              scan_done;
    logic              gap_done;

    assign load.load_ready = !clear;
    assign accept          = load.load_valid && load.load_ready;
    assign scan_done       = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
    assign gap_done        = (gap_cnt == 8'(GAP_CYC - 1));

    // Highest set bit wins; later iterations override earlier ones.
    always_comb begin
        enc = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (load.in[i]) begin
                enc = 4'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= SCAN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            SCAN: if (scan_done) state_next = GAP;
            GAP:  if (gap_done)  state_next = SCAN;
            default: state_next = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            gap_cnt  <= '0;
            idx      <= '0;
        end else begin
            case (state)
                SCAN: begin
                    if (scan_done) begin
                        scan_cnt <= '0;
                    end else begin
                        scan_cnt <= scan_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_done) begin
                        gap_cnt <= '0;
                        idx     <= idx + 2'd1;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Remembers the last driven digit value so code stays stable through GAP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            code_last <= '0;
        end else if (state == SCAN) begin
            code_last <= d_val[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            d_val <= '0;
            d_vld <= '0;
        end else if (accept) begin
            d_val <= {d_val[2:0], enc};
            d_vld <= {d_vld[2:0], |load.in};
        end
    end

    always_comb begin
        digit_sel = '0;
        code      = code_last;
        blank     = 1'b1;
        case (state)
            SCAN: begin
                digit_sel = 4'b0001 << idx;
                code      = d_val[idx];
                blank     = !d_vld[idx];
            end
            GAP: ;
            default: ;
        endcase
    end

`ifdef SEG_SCAN_MULTIHOT_ERR_EN
    logic multi_hot;

    // x & (x-1) is non-zero exactly when two or more bits are set.
    assign multi_hot = |(load.in & (load.in - 16'd1));

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            err <= 1'b0;
        end else if (accept && multi_hot) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Directed scoreboard bench for seg_scan_scheduler (SCAN_DIV=4, GAP_CYC=1).
module tb_seg_scan_scheduler;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned GAP_CYC  = 1;
    localparam int unsigned SLOT     = SCAN_DIV + GAP_CYC;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic [3:0] code;
    logic       blank;
    logic [3:0] digit_sel;
    logic       err;

    seg_scan_scheduler_if bus();

    seg_scan_scheduler #(
        .SCAN_DIV (SCAN_DIV),
        .GAP_CYC  (GAP_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (bus.slave),
        .clear     (clear),
        .code      (code),
        .blank     (blank),
        .digit_sel (digit_sel),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] sel;
        logic [3:0] code;
        logic       blank;
        logic       err;
    } obs_t;

    obs_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned k = 0;
    logic [3:0]  mval[4];
    logic        mvld[4];
    logic [3:0]  last_code = '0;
    logic        merr = 1'b0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic obs_t model_out();
        obs_t        o;
        int unsigned slot;
        slot = (k / SLOT) % 4;
        o.err = merr;
        if ((k % SLOT) < SCAN_DIV) begin
            o.sel   = 4'(1 << slot);
            o.code  = mval[slot];
            o.blank = !mvld[slot];
        end else begin
            o.sel   = 4'b0000;
            o.code  = last_code;
            o.blank = 1'b1;
        end
        return o;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            mval[i] = '0;
            mvld[i] = 1'b0;
        end
        merr = 1'b0;
    endtask

    // One clock: update the model from the inputs seen at the edge, push the
    // expected outputs, then pop and compare against the DUT.
    task automatic step();
        obs_t       cur;
        obs_t       e;
        logic [3:0] enc;
        logic       acc;
        acc = rst_n && bus.load_valid && !clear;
        enc = '0;
        for (int i = 0; i < 16; i++) begin
            if (bus.in[i]) enc = 4'(i);
        end
        cur = model_out();
        @(posedge clk);
        if (!rst_n) begin
            k = 0;
            last_code = '0;
            clear_model();
        end else begin
            if (cur.sel != 4'b0000) last_code = cur.code;
            k++;
            if (clear) begin
                clear_model();
            end else if (acc) begin
`ifdef SEG_SCAN_MULTIHOT_ERR_EN
                if ($countones(bus.in) >= 2) merr = 1'b1;
`endif
                for (int i = 3; i > 0; i--) begin
                    mval[i] = mval[i-1];
                    mvld[i] = mvld[i-1];
                end
                mval[0] = enc;
                mvld[0] = |bus.in;
            end
        end
        #1;
        exp_q.push_back(model_out());
        e = exp_q.pop_front();
        check("digit_sel", 16'(digit_sel), 16'(e.sel));
        check("code",      16'(code),      16'(e.code));
        check("blank",     16'(blank),     16'(e.blank));
        check("err",       16'(err),       16'(e.err));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic accept(input logic [15:0] v);
        bus.in         = v;
        bus.load_valid = 1'b1;
        step();
        bus.load_valid = 1'b0;
        bus.in         = '0;
    endtask

    initial begin
        logic found;
        clear_model();
        rst_n          = 1'b0;
        clear          = 1'b0;
        bus.load_valid = 1'b0;
        bus.in         = '0;

        // Reset state, with an accept attempt that must be discarded.
        step();
        bus.load_valid = 1'b1;
        bus.in         = 16'h0040;
        step();
        bus.load_valid = 1'b0;
        bus.in         = '0;
        check("reset_sel", 16'(digit_sel), 16'h0001);
        check("load_ready_idle", 16'(bus.load_ready), 16'h0001);

        // Idle scan pattern.
        rst_n = 1'b1;
        run(40);

        // Single accept shows on slot 0.
        accept(16'h0020);
        run(20);

        // Back-to-back accepts with shift-out of the oldest entry.
        accept(16'h8001);
        accept(16'h0000);
        accept(16'h0004);
        accept(16'h0100);
        accept(16'h0002);
        run(20);

        // Clear beats a coincident load.
        clear          = 1'b1;
        bus.load_valid = 1'b1;
        bus.in         = 16'h0010;
        #1;
        check("load_ready_clear", 16'(bus.load_ready), 16'h0000);
        step();
        clear          = 1'b0;
        bus.load_valid = 1'b0;
        bus.in         = '0;
        run(20);

        // Multi-hot request, then clear drops the flag.
        accept(16'h0003);
        run(20);
        clear = 1'b1;
        step();
        clear = 1'b0;
        run(5);

        // Reset while in the gap between slot 2 and slot 3.
        accept(16'h0200);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if ((k % SLOT) >= SCAN_DIV && ((k / SLOT) % 4) == 2) found = 1'b1;
            else step();
        end
        check("gap_search", 16'(found), 16'h0001);
        rst_n          = 1'b0;
        bus.load_valid = 1'b1;
        bus.in         = 16'hffff;
        step();
        check("reset_gap_sel", 16'(digit_sel), 16'h0001);
        check("reset_gap_blank", 16'(blank), 16'h0001);
        rst_n          = 1'b1;
        bus.load_valid = 1'b0;
        bus.in         = '0;
        run(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
